// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocation, CDB, operand-query and commit signals of the reorder buffer
interface reorder_buffer_if #(parameter int ROB_WIDTH = 4);
   logic                 allocValid;
   logic [1:0]           allocType;
   logic [4:0]           allocDest;
   logic [ROB_WIDTH-1:0] allocRobId;
   logic                 robFull;
   logic                 cdbValid;
   logic [ROB_WIDTH-1:0] cdbRobId;
   logic [31:0]          cdbValue;
   logic                 cdbMispredict;
   logic [31:0]          cdbNewPc;
   logic [ROB_WIDTH-1:0] robRs1Dep;
   logic                 robRs1Ready;
   logic [31:0]          robRs1Value;
   logic [ROB_WIDTH-1:0] robRs2Dep;
   logic                 robRs2Ready;
   logic [31:0]          robRs2Value;
   logic                 regUpdateValid;
   logic [4:0]           regUpdateDest;
   logic [31:0]          regUpdateValue;
   logic [ROB_WIDTH-1:0] regUpdateRobId;
   logic                 storeCommitValid;
   logic [ROB_WIDTH-1:0] storeCommitRobId;
   logic                 flushValid;
   logic [31:0]          flushPc;
   modport master (
      output allocValid, allocType, allocDest, cdbValid, cdbRobId, cdbValue, cdbMispredict, cdbNewPc,
             robRs1Dep, robRs2Dep,
      input  allocRobId, robFull, robRs1Ready, robRs1Value, robRs2Ready, robRs2Value,
             regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
             storeCommitValid, storeCommitRobId, flushValid, flushPc
   );
   modport slave (
      input  allocValid, allocType, allocDest, cdbValid, cdbRobId, cdbValue, cdbMispredict, cdbNewPc,
             robRs1Dep, robRs2Dep,
      output allocRobId, robFull, robRs1Ready, robRs1Value, robRs2Ready, robRs2Value,
             regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
             storeCommitValid, storeCommitRobId, flushValid, flushPc
   );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB with CDB capture, operand bypass, in-order commit and mispredict flush
module reorder_buffer #(parameter int ROB_WIDTH = 4) (
   input logic clockIn,
   input logic resetIn,
   reorder_buffer_if.slave bus
);
   localparam int DEPTH = 1 << ROB_WIDTH;
   localparam int CW = ROB_WIDTH + 1;
   logic [DEPTH-1:0]     busy, ready;
   logic [1:0]           kind [DEPTH];
   logic [4:0]           dest [DEPTH];
   logic [31:0]          value [DEPTH];
   logic [31:0]          newPc [DEPTH];
   logic [DEPTH-1:0]     mispredict;
   logic [ROB_WIDTH-1:0] head, tail;
   logic [CW-1:0]        count;
   logic                 doAlloc, cdbWrite, commit, flush, rs1Hit, rs2Hit;
   assign bus.robFull = count == CW'(DEPTH);
   assign bus.allocRobId = tail;
   assign doAlloc = bus.allocValid && !bus.robFull;
   assign cdbWrite = bus.cdbValid && busy[bus.cdbRobId];
   // commit only looks at the registered ready bit; a same-cycle CDB hit waits one edge
   assign commit = count != '0 && ready[head];
   assign flush = commit && kind[head] == 2'd2 && mispredict[head];
   assign rs1Hit = bus.cdbValid && bus.cdbRobId == bus.robRs1Dep;
   assign rs2Hit = bus.cdbValid && bus.cdbRobId == bus.robRs2Dep;
   assign bus.robRs1Ready = ready[bus.robRs1Dep] || rs1Hit;
   assign bus.robRs1Value = rs1Hit ? bus.cdbValue : value[bus.robRs1Dep];
   assign bus.robRs2Ready = ready[bus.robRs2Dep] || rs2Hit;
   assign bus.robRs2Value = rs2Hit ? bus.cdbValue : value[bus.robRs2Dep];
   always_ff @(posedge clockIn or negedge resetIn)
      if (!resetIn) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         busy <= '0;
         ready <= '0;
         bus.regUpdateValid <= 1'b0;
         bus.regUpdateDest <= '0;
         bus.regUpdateValue <= '0;
         bus.regUpdateRobId <= '0;
         bus.storeCommitValid <= 1'b0;
         bus.storeCommitRobId <= '0;
         bus.flushValid <= 1'b0;
         bus.flushPc <= '0;
      end else begin
         bus.regUpdateValid <= 1'b0;
         bus.regUpdateDest <= '0;
         bus.regUpdateValue <= '0;
         bus.regUpdateRobId <= '0;
         bus.storeCommitValid <= 1'b0;
         bus.storeCommitRobId <= '0;
         bus.flushValid <= 1'b0;
         bus.flushPc <= '0;
         if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            busy <= '0;
            ready <= '0;
            bus.flushValid <= 1'b1;
            bus.flushPc <= newPc[head];
         end else begin
            if (doAlloc) begin
               busy[tail] <= 1'b1;
               ready[tail] <= 1'b0;
               tail <= tail + ROB_WIDTH'(1);
            end
            if (cdbWrite) ready[bus.cdbRobId] <= 1'b1;
            if (commit) begin
               busy[head] <= 1'b0;
               ready[head] <= 1'b0;
               head <= head + ROB_WIDTH'(1);
               bus.regUpdateValid <= kind[head] == 2'd0;
               bus.regUpdateDest <= kind[head] == 2'd0 ? dest[head] : 5'd0;
               bus.regUpdateValue <= kind[head] == 2'd0 ? value[head] : 32'd0;
               bus.regUpdateRobId <= kind[head] == 2'd0 ? head : '0;
               bus.storeCommitValid <= kind[head] == 2'd1;
               bus.storeCommitRobId <= kind[head] == 2'd1 ? head : '0;
            end
            count <= count + CW'(doAlloc) - CW'(commit);
         end
      end
   // payload fields need no reset: busy/ready gate every use
   always_ff @(posedge clockIn) begin
      if (doAlloc && !flush) begin
         kind[tail] <= bus.allocType;
         dest[tail] <= bus.allocDest;
      end
      if (cdbWrite && !flush) begin
         value[bus.cdbRobId] <= bus.cdbValue;
         newPc[bus.cdbRobId] <= bus.cdbNewPc;
      end
   end
   always_ff @(posedge clockIn or negedge resetIn)
      if (!resetIn) mispredict <= '0;
      else if (!flush) begin
         if (doAlloc) mispredict[tail] <= 1'b0;
         if (cdbWrite) mispredict[bus.cdbRobId] <= bus.cdbMispredict;
      end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenario tests of the reorder buffer with hand-computed expectations
module tb_reorder_buffer;
   logic clockIn = 1'b0;
   logic resetIn = 1'b0;
   int checks = 0;
   int errors = 0;
   reorder_buffer_if #(.ROB_WIDTH(4)) bus ();
   reorder_buffer #(.ROB_WIDTH(4)) dut (.clockIn(clockIn), .resetIn(resetIn), .bus(bus.slave));
   always #5 clockIn = ~clockIn;
   task automatic tick();
      @(posedge clockIn);
      #1;
   endtask
   task automatic idle_inputs();
      bus.allocValid = 0; bus.allocType = 0; bus.allocDest = 0;
      bus.cdbValid = 0; bus.cdbRobId = 0; bus.cdbValue = 0; bus.cdbMispredict = 0; bus.cdbNewPc = 0;
      bus.robRs1Dep = 0; bus.robRs2Dep = 0;
   endtask
   task automatic alloc(input logic [1:0] t, input logic [4:0] d);
      bus.allocValid = 1; bus.allocType = t; bus.allocDest = d;
      tick();
      bus.allocValid = 0;
   endtask
   task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic m, input logic [31:0] pc);
      bus.cdbValid = 1; bus.cdbRobId = id; bus.cdbValue = v; bus.cdbMispredict = m; bus.cdbNewPc = pc;
      tick();
      bus.cdbValid = 0; bus.cdbMispredict = 0;
   endtask
   task automatic do_reset();
      idle_inputs();
      @(negedge clockIn);
      resetIn = 0;
      #2;
      resetIn = 1;
      tick();
   endtask
   task automatic test_reset();
      idle_inputs();
      resetIn = 0;
      #12;
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL reset_regUpdateValid got %0h exp 0", bus.regUpdateValid); end
      checks++; if (bus.robFull !== 1'b0) begin errors++; $display("FAIL reset_robFull got %0h exp 0", bus.robFull); end
      checks++; if (bus.allocRobId !== 4'd0) begin errors++; $display("FAIL reset_allocRobId got %0h exp 0", bus.allocRobId); end
      checks++; if ({bus.storeCommitValid, bus.flushValid, bus.flushPc} !== 34'd0) begin errors++; $display("FAIL reset_commit_outs got %0h exp 0", {bus.storeCommitValid, bus.flushValid, bus.flushPc}); end
      resetIn = 1;
      tick();
   endtask
   task automatic test_basic_commit();
      do_reset();
      alloc(2'd0, 5'd5);
      cdb(4'd0, 32'h1234, 0, 0);
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL basic_early got %0h exp 0", bus.regUpdateValid); end
      tick();
      checks++; if ({bus.regUpdateValid, bus.regUpdateDest, bus.regUpdateValue, bus.regUpdateRobId} !== {1'b1, 5'd5, 32'h1234, 4'd0})
         begin errors++; $display("FAIL basic_commit got v%0h d%0h val%0h id%0h exp v1 d5 val1234 id0", bus.regUpdateValid, bus.regUpdateDest, bus.regUpdateValue, bus.regUpdateRobId); end
      tick();
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0h exp 0", bus.regUpdateValid); end
   endtask
   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) alloc(2'd0, 5'(i));
      checks++; if (bus.robFull !== 1'b1) begin errors++; $display("FAIL full_flag got %0h exp 1", bus.robFull); end
      checks++; if (bus.allocRobId !== 4'd0) begin errors++; $display("FAIL full_id got %0h exp 0", bus.allocRobId); end
      alloc(2'd0, 5'd31);
      checks++; if ({bus.robFull, bus.allocRobId} !== 5'b1_0000) begin errors++; $display("FAIL full_17th got full%0h id%0h exp full1 id0", bus.robFull, bus.allocRobId); end
      cdb(4'd0, 32'h77, 0, 0);
      tick();
      checks++; if ({bus.regUpdateValid, bus.regUpdateRobId, bus.robFull} !== {1'b1, 4'd0, 1'b0})
         begin errors++; $display("FAIL full_commit got v%0h id%0h full%0h exp v1 id0 full0", bus.regUpdateValid, bus.regUpdateRobId, bus.robFull); end
      tick();
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL full_single got %0h exp 0", bus.regUpdateValid); end
   endtask
   task automatic test_out_of_order();
      do_reset();
      for (int i = 0; i < 3; i++) alloc(2'd0, 5'(i + 1));
      cdb(4'd2, 32'h102, 0, 0);
      cdb(4'd1, 32'h101, 0, 0);
      cdb(4'd0, 32'h100, 0, 0);
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL ooo_early got %0h exp 0", bus.regUpdateValid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({bus.regUpdateValid, bus.regUpdateRobId, bus.regUpdateDest, bus.regUpdateValue} !== {1'b1, 4'(i), 5'(i + 1), 32'h100 + 32'(i)})
            begin errors++; $display("FAIL ooo_commit%0d got v%0h id%0h d%0h val%0h", i, bus.regUpdateValid, bus.regUpdateRobId, bus.regUpdateDest, bus.regUpdateValue); end
      end
      tick();
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL ooo_tail got %0h exp 0", bus.regUpdateValid); end
   endtask
   task automatic test_bypass();
      do_reset();
      for (int i = 0; i < 4; i++) alloc(2'd0, 5'd9);
      bus.robRs1Dep = 4'd3; bus.robRs2Dep = 4'd2;
      bus.cdbValid = 1; bus.cdbRobId = 4'd3; bus.cdbValue = 32'hDEAD;
      #1;
      checks++; if ({bus.robRs1Ready, bus.robRs1Value} !== {1'b1, 32'hDEAD}) begin errors++; $display("FAIL bypass_rs1 got r%0h v%0h exp r1 vdead", bus.robRs1Ready, bus.robRs1Value); end
      checks++; if (bus.robRs2Ready !== 1'b0) begin errors++; $display("FAIL bypass_rs2 got %0h exp 0", bus.robRs2Ready); end
      tick();
      bus.cdbValid = 0;
      #1;
      checks++; if ({bus.robRs1Ready, bus.robRs1Value} !== {1'b1, 32'hDEAD}) begin errors++; $display("FAIL stored_rs1 got r%0h v%0h exp r1 vdead", bus.robRs1Ready, bus.robRs1Value); end
      cdb(4'd9, 32'h5555, 0, 0);
      bus.robRs1Dep = 4'd9;
      #1;
      checks++; if (bus.robRs1Ready !== 1'b0) begin errors++; $display("FAIL nonbusy_cdb got %0h exp 0", bus.robRs1Ready); end
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL bypass_nocommit got %0h exp 0", bus.regUpdateValid); end
   endtask
   task automatic test_types();
      do_reset();
      alloc(2'd1, 5'd0);
      alloc(2'd2, 5'd0);
      alloc(2'd0, 5'd0);
      cdb(4'd0, 32'h1, 0, 0);
      cdb(4'd1, 32'h2, 0, 32'h400);
      checks++; if ({bus.storeCommitValid, bus.storeCommitRobId, bus.regUpdateValid} !== {1'b1, 4'd0, 1'b0})
         begin errors++; $display("FAIL store_commit got s%0h id%0h r%0h exp s1 id0 r0", bus.storeCommitValid, bus.storeCommitRobId, bus.regUpdateValid); end
      cdb(4'd2, 32'h3, 0, 0);
      checks++; if ({bus.storeCommitValid, bus.regUpdateValid, bus.flushValid} !== 3'b000)
         begin errors++; $display("FAIL branch_ok got %0b exp 000", {bus.storeCommitValid, bus.regUpdateValid, bus.flushValid}); end
      tick();
      checks++; if ({bus.regUpdateValid, bus.regUpdateDest, bus.regUpdateRobId, bus.regUpdateValue} !== {1'b1, 5'd0, 4'd2, 32'h3})
         begin errors++; $display("FAIL x0_commit got v%0h d%0h id%0h val%0h exp v1 d0 id2 val3", bus.regUpdateValid, bus.regUpdateDest, bus.regUpdateRobId, bus.regUpdateValue); end
   endtask
   task automatic test_mispredict();
      do_reset();
      alloc(2'd2, 5'd0);
      alloc(2'd0, 5'd7);
      cdb(4'd1, 32'h55, 0, 0);
      cdb(4'd0, 32'h0, 1, 32'h100);
      tick();
      checks++; if ({bus.flushValid, bus.flushPc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL flush got v%0h pc%0h exp v1 pc100", bus.flushValid, bus.flushPc); end
      checks++; if ({bus.regUpdateValid, bus.allocRobId, bus.robFull} !== {1'b0, 4'd0, 1'b0})
         begin errors++; $display("FAIL flush_state got r%0h id%0h full%0h exp r0 id0 full0", bus.regUpdateValid, bus.allocRobId, bus.robFull); end
      tick();
      checks++; if ({bus.flushValid, bus.regUpdateValid} !== 2'b00) begin errors++; $display("FAIL flush_after got %0b exp 00", {bus.flushValid, bus.regUpdateValid}); end
   endtask
   task automatic test_wrap_and_reset();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         checks++; if (bus.allocRobId !== 4'(i)) begin errors++; $display("FAIL wrap_id%0d got %0h exp %0h", i, bus.allocRobId, 4'(i)); end
         alloc(2'd0, 5'(i));
         cdb(4'(i), 32'hA000 + 32'(i), 0, 0);
         tick();
         checks++; if ({bus.regUpdateValid, bus.regUpdateRobId, bus.regUpdateValue} !== {1'b1, 4'(i), 32'hA000 + 32'(i)})
            begin errors++; $display("FAIL wrap_commit%0d got v%0h id%0h val%0h", i, bus.regUpdateValid, bus.regUpdateRobId, bus.regUpdateValue); end
      end
      for (int i = 0; i < 3; i++) alloc(2'd0, 5'd3);
      cdb(4'd4, 32'hBEEF, 0, 0);
      tick();
      checks++; if (bus.regUpdateValid !== 1'b1) begin errors++; $display("FAIL prereset_commit got %0h exp 1", bus.regUpdateValid); end
      #2;
      resetIn = 0;
      #1;
      checks++; if ({bus.regUpdateValid, bus.regUpdateValue, bus.robFull, bus.allocRobId} !== {1'b0, 32'd0, 1'b0, 4'd0})
         begin errors++; $display("FAIL midreset got v%0h val%0h full%0h id%0h exp all 0", bus.regUpdateValid, bus.regUpdateValue, bus.robFull, bus.allocRobId); end
      #3;
      resetIn = 1;
      tick();
      tick();
      checks++; if (bus.regUpdateValid !== 1'b0) begin errors++; $display("FAIL postreset_idle got %0h exp 0", bus.regUpdateValid); end
   endtask
   initial begin
      test_reset();
      test_basic_commit();
      test_full();
      test_out_of_order();
      test_bypass();
      test_types();
      test_mispredict();
      test_wrap_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
